// File: rtl/brick_field_painter.sv
// Brick field painter: draws a NUM_ROWS x BLOCKS_PER_ROW grid of 2-bit-strength
// bricks. Row masks are fetched over a req/valid handshake into a back buffer
// and swapped into the front (drawn) buffer at the top of each brick row.
module brick_field_painter #(
  parameter int LEFT           = 8,
  parameter int TOP            = 8,
  parameter int BLOCK_WIDTH    = 48,
  parameter int BLOCK_HEIGHT   = 20,
  parameter int BLOCKS_PER_ROW = 13,
  parameter int NUM_ROWS       = 16,
  parameter int GAP            = 1,
  parameter logic [5:0] COLOR_S1 = 6'b000011,
  parameter logic [5:0] COLOR_S2 = 6'b001100,
  parameter logic [5:0] COLOR_S3 = 6'b110000
) (
  input  logic                          clk,
  input  logic                          nRst,
  input  logic [9:0]                    hpos,
  input  logic [8:0]                    vpos,
  input  logic                          new_frame,
  input  logic                          new_line,
  input  logic                          display_active,
  output logic                          row_req,
  output logic [$clog2(NUM_ROWS)-1:0]   row_idx,
  input  logic [2*BLOCKS_PER_ROW-1:0]   row_data,
  input  logic                          row_valid,
  output logic                          block_en,
  output logic [5:0]                    color,
  output logic                          underrun
);

  localparam int CW = $clog2(BLOCKS_PER_ROW + 1);
  localparam int RW = $clog2(NUM_ROWS + 1);
  localparam int IW = $clog2(NUM_ROWS);
  localparam int DW = 2 * BLOCKS_PER_ROW;

  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   row_idx_next;
  logic [DW-1:0]   front, front_next;
  logic [DW-1:0]   back, back_next;
  logic            underrun_next;

  // Geometry: offsets into the field, brick column/row and in-brick position.
  int              dx, dy, x, y;
  logic [BLOCKS_PER_ROW-1:0] col_ge;
  logic [NUM_ROWS-1:0]       row_ge;
  logic [CW-1:0]   col, col_sel;
  logic [RW-1:0]   row;
  logic            in_field, gap, swap, pix_on;
  logic [1:0]      strength;
  logic [5:0]      pix_color;

  assign dx = int'({22'd0, hpos}) - LEFT;
  assign dy = int'({23'd0, vpos}) - TOP;

  // Thermometer codes: one comparator per brick boundary instead of a divider.
  // The number of boundaries passed is the brick index.
  generate
    for (genvar gi = 0; gi < BLOCKS_PER_ROW; gi++) begin : g_col
      assign col_ge[gi] = (dx >= (gi + 1) * BLOCK_WIDTH);
    end
    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      assign row_ge[gi] = (dy >= (gi + 1) * BLOCK_HEIGHT);
    end
  endgenerate

  // Count boundaries passed to get column/row, then derive in-brick offsets.
  always_comb begin
    col = '0;
    row = '0;
    for (int i = 0; i < BLOCKS_PER_ROW; i++) col = col + CW'(col_ge[i]);
    for (int i = 0; i < NUM_ROWS; i++) row = row + RW'(row_ge[i]);
  end

  assign x = dx - int'(col) * BLOCK_WIDTH;
  assign y = dy - int'(row) * BLOCK_HEIGHT;

  assign in_field = display_active && (dx >= 0) && (dy >= 0) &&
                    (int'(col) < BLOCKS_PER_ROW) && (int'(row) < NUM_ROWS);
  assign gap      = (x < GAP) || (x >= BLOCK_WIDTH - GAP) ||
                    (y < GAP) || (y >= BLOCK_HEIGHT - GAP);
  assign col_sel  = (int'(col) < BLOCKS_PER_ROW) ? col : '0;
  assign strength = front[2*int'(col_sel) +: 2];
  assign pix_on   = in_field && !gap && (strength != 2'd0);

  // Brick colour lookup; black whenever the pixel is not drawn.
  always_comb begin
    pix_color = 6'd0;
    if (pix_on) begin
      case (strength)
        2'd1:    pix_color = COLOR_S1;
        2'd2:    pix_color = COLOR_S2;
        default: pix_color = COLOR_S3;
      endcase
    end
  end

  // First line of a brick row: time to swap the prefetched row into view.
  assign swap = new_line && (dy >= 0) && (int'(row) < NUM_ROWS) && (y == 0);

  assign row_req = (state == FETCH);

  // Fetch/swap next-state: new_frame beats a swap, a swap beats an ack.
  always_comb begin
    state_next    = state;
    row_idx_next  = row_idx;
    front_next    = front;
    back_next     = back;
    underrun_next = underrun;
    if (new_frame) begin
      state_next    = FETCH;
      row_idx_next  = '0;
      front_next    = '0;
      back_next     = '0;
      underrun_next = 1'b0;
    end else if (swap) begin
      if (state == FULL) begin
        front_next = back;
      end else begin
        front_next    = '0;
        underrun_next = 1'b1;
      end
      if (int'(row) + 1 < NUM_ROWS) begin
        row_idx_next = IW'(int'(row) + 1);
        state_next   = FETCH;
      end else begin
        state_next = IDLE;
      end
    end else if (state == FETCH && row_valid) begin
      back_next  = row_data;
      state_next = FULL;
    end
  end

  // Fetch FSM state, buffers and sticky underrun flag.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= IDLE;
      row_idx  <= '0;
      front    <= '0;
      back     <= '0;
      underrun <= 1'b0;
    end else begin
      state    <= state_next;
      row_idx  <= row_idx_next;
      front    <= front_next;
      back     <= back_next;
      underrun <= underrun_next;
    end
  end

  // Registered pixel outputs, one cycle behind hpos/vpos.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      block_en <= 1'b0;
      color    <= 6'd0;
    end else begin
      block_en <= pix_on;
      color    <= pix_color;
    end
  end

endmodule

// File: tb/tb_brick_field_painter.sv
// Self-checking bench for brick_field_painter: pixel expectations go through a
// scoreboard queue; fetch/swap behaviour is checked directly after each step.
module tb_brick_field_painter;

  localparam int L = 8, T = 8, BW = 48, BH = 20, BPR = 13, NR = 16, G = 1;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [9:0]  hpos = '0;
  logic [8:0]  vpos = '0;
  logic        new_frame = 1'b0;
  logic        new_line = 1'b0;
  logic        display_active = 1'b0;
  logic        row_req;
  logic [3:0]  row_idx;
  logic [25:0] row_data = '0;
  logic        row_valid = 1'b0;
  logic        block_en;
  logic [5:0]  color;
  logic        underrun;

  int n_vec = 0;
  int n_miss = 0;
  logic [6:0]  exp_q[$];
  logic [25:0] front_m = '0;

  brick_field_painter dut (
    .clk(clk), .nRst(nRst), .hpos(hpos), .vpos(vpos),
    .new_frame(new_frame), .new_line(new_line), .display_active(display_active),
    .row_req(row_req), .row_idx(row_idx), .row_data(row_data), .row_valid(row_valid),
    .block_en(block_en), .color(color), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference pixel model using plain division on the bench side.
  function automatic logic [6:0] ref_pix(int h, int v, logic [25:0] fr);
    int dx, dy, c, r, x, y;
    logic [1:0] s;
    dx = h - L;
    dy = v - T;
    if (dx < 0 || dy < 0) return 7'd0;
    c = dx / BW; x = dx % BW;
    r = dy / BH; y = dy % BH;
    if (c >= BPR || r >= NR) return 7'd0;
    if (x < G || x >= BW - G || y < G || y >= BH - G) return 7'd0;
    s = fr[2*c +: 2];
    case (s)
      2'd1:    return {1'b1, 6'b000011};
      2'd2:    return {1'b1, 6'b001100};
      2'd3:    return {1'b1, 6'b110000};
      default: return 7'd0;
    endcase
  endfunction

  task automatic pix(input int h, input int v);
    logic [6:0] e;
    hpos = 10'(h);
    vpos = 9'(v);
    display_active = 1'b1;
    exp_q.push_back(ref_pix(h, v, front_m));
    tick();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("pix_en(%0d,%0d)", h, v), 32'(block_en), 32'(e[6]));
      chk($sformatf("pix_col(%0d,%0d)", h, v), 32'(color), 32'(e[5:0]));
    end
  endtask

  task automatic nl(input int v);
    vpos = 9'(v);
    hpos = '0;
    display_active = 1'b0;
    new_line = 1'b1;
    tick();
    new_line = 1'b0;
  endtask

  task automatic frame();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    front_m = '0;
  endtask

  task automatic ack(input logic [25:0] d, input int idx);
    int waited;
    waited = 0;
    while (!row_req && waited < 50) begin
      tick();
      waited++;
    end
    if (!row_req) begin
      chk("ack_timeout", 32'd0, 32'd1);
    end else begin
      chk("ack_idx", 32'(row_idx), 32'(idx));
      row_data = d;
      row_valid = 1'b1;
      tick();
      row_valid = 1'b0;
      chk("ack_req_drop", 32'(row_req), 32'd0);
    end
  endtask

  initial begin
    logic [25:0] d;
    // Reset state
    #2;
    chk("rst_en", 32'(block_en), 32'd0);
    chk("rst_req", 32'(row_req), 32'd0);
    chk("rst_idx", 32'(row_idx), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    tick();
    nRst = 1'b1;
    tick();

    // 1: single strength-3 brick in row 0
    frame();
    chk("t1_req", 32'(row_req), 32'd1);
    ack(26'h3, 0);
    nl(8);
    front_m = 26'h3;
    chk("t1_swap_req", 32'(row_req), 32'd1);
    chk("t1_swap_idx", 32'(row_idx), 32'd1);
    nl(9);
    pix(9, 9);
    pix(54, 9);
    pix(8, 9);
    pix(55, 9);
    pix(56, 9);
    pix(9, 8);

    // 2: request held while unacknowledged
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i % 20 == 0) begin
        chk("t2_hold_req", 32'(row_req), 32'd1);
        chk("t2_hold_idx", 32'(row_idx), 32'd1);
      end
    end
    ack(26'h20, 1);
    nl(28);
    front_m = 26'h20;
    pix(105, 30);
    pix(9, 30);

    // 3: row 1 never acknowledged
    frame();
    ack(26'h3, 0);
    nl(8);
    front_m = 26'h3;
    chk("t3_pre_underrun", 32'(underrun), 32'd0);
    nl(28);
    front_m = '0;
    chk("t3_underrun", 32'(underrun), 32'd1);
    chk("t3_req", 32'(row_req), 32'd1);
    chk("t3_idx", 32'(row_idx), 32'd2);
    pix(9, 30);
    pix(105, 30);

    // 4: new_frame and new_line together during row-5 fetch
    frame();
    for (int r = 0; r < 5; r++) nl(8 + 20 * r);
    chk("t4_idx5", 32'(row_idx), 32'd5);
    chk("t4_underrun_set", 32'(underrun), 32'd1);
    vpos = 9'd108;
    new_line = 1'b1;
    new_frame = 1'b1;
    tick();
    new_line = 1'b0;
    new_frame = 1'b0;
    front_m = '0;
    chk("t4_idx0", 32'(row_idx), 32'd0);
    chk("t4_underrun_clr", 32'(underrun), 32'd0);
    chk("t4_req", 32'(row_req), 32'd1);

    // 5: full frame with strengths 1,2,3 cycling
    frame();
    for (int r = 0; r < NR; r++) begin
      d = '0;
      for (int i = 0; i < BPR; i++) d[2*i +: 2] = 2'(((i + r) % 3) + 1);
      ack(d, r);
      nl(8 + 20 * r);
      front_m = d;
      pix(8 + 24, 18 + 20 * r);
      pix(8 + 48 * 6 + 24, 18 + 20 * r);
      pix(8 + 48 * 12 + 24, 18 + 20 * r);
      pix(8 + 48 * 6, 18 + 20 * r);
    end
    chk("t5_idle_req", 32'(row_req), 32'd0);
    repeat (5) tick();
    chk("t5_idle_req_later", 32'(row_req), 32'd0);
    chk("t5_underrun", 32'(underrun), 32'd0);
    nl(328);
    pix(32, 330);
    pix(640, 318);

    // 6: asynchronous reset mid-line
    frame();
    ack(26'h3, 0);
    nl(8);
    nl(28);
    ack(26'h3, 2);
    nl(48);
    front_m = 26'h3;
    pix(9, 50);
    chk("t6_pre_underrun", 32'(underrun), 32'd1);
    chk("t6_pre_req", 32'(row_req), 32'd1);
    #3;
    nRst = 1'b0;
    #1;
    chk("t6_en", 32'(block_en), 32'd0);
    chk("t6_color", 32'(color), 32'd0);
    chk("t6_req", 32'(row_req), 32'd0);
    chk("t6_underrun", 32'(underrun), 32'd0);
    chk("t6_idx", 32'(row_idx), 32'd0);
    tick();
    nRst = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
